// File: rtl/audio_dac_serializer.sv
// I2S serializer for the WM8731 dacdat input: mono samples arrive over a
// valid/ready sink, are buffered in a small FIFO and sent on both channels.
module audio_dac_serializer #(
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             sample_data,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  input  logic                          mute,
  input  logic                          bclk_i,
  input  logic                          daclrck_i,
  output logic                          dacdat_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   underrun_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] WORD_BITS = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
  logic [SYNC_STAGES-1:0] lr_sync_q, lr_sync_d;
  logic                   bclk_prev_q, bclk_prev_d;
  logic                   lr_prev_q, lr_prev_d;

  logic [DATA_W-1:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   sample_ready_q, sample_ready_d;
  logic [DATA_W-1:0]      hold_q, hold_d;
  logic [15:0]            underrun_q, underrun_d;

  state_t                 state_q, state_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   dacdat_q, dacdat_d;

  logic                   bclk_s, lr_s, bclk_fall_s, chan_start_s, left_start_s;
  logic                   fifo_empty_s, push_s, pop_s, underrun_s;
  logic [DATA_W-1:0]      load_word_s;

  // Event decode: codec clocks are resynchronised, then edges/starts derived.
  always_comb begin
    bclk_sync_d  = (bclk_sync_q << 1) | SYNC_STAGES'(bclk_i);
    lr_sync_d    = (lr_sync_q << 1) | SYNC_STAGES'(daclrck_i);
    bclk_s       = bclk_sync_q[SYNC_STAGES-1];
    lr_s         = lr_sync_q[SYNC_STAGES-1];
    bclk_prev_d  = bclk_s;
    bclk_fall_s  = bclk_prev_q & ~bclk_s;
    chan_start_s = bclk_fall_s & (lr_s != lr_prev_q);
    left_start_s = chan_start_s & ~lr_s;
    if (bclk_fall_s) begin
      lr_prev_d = lr_s;
    end else begin
      lr_prev_d = lr_prev_q;
    end
    fifo_empty_s = (level_q == {LVL_W{1'b0}});
    push_s       = sample_valid & sample_ready_q;
    pop_s        = left_start_s & ~fifo_empty_s;
    underrun_s   = left_start_s & fifo_empty_s;
  end

  // FIFO bookkeeping; pop sees pre-push contents, so empty+push is an underrun.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    hold_d     = hold_q;
    underrun_d = underrun_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      hold_d   = mem_q[rd_ptr_q];
    end else begin
      rd_ptr_d = rd_ptr_q;
      hold_d   = hold_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (underrun_s && (underrun_q != 16'hFFFF)) begin
      underrun_d = underrun_q + 16'd1;
    end else begin
      underrun_d = underrun_q;
    end
    sample_ready_d = (level_d < DEPTH_LVL);
  end

  // Serializer FSM: a channel start always wins, even mid-word.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    dacdat_d    = dacdat_q;
    load_word_s = mute ? {DATA_W{1'b0}} : hold_d;
    if (chan_start_s) begin
      shift_d   = load_word_s;
      bit_cnt_d = WORD_BITS;
      dacdat_d  = 1'b0;
      state_d   = ST_DELAY;
    end else if (bclk_fall_s) begin
      case (state_q)
        ST_DELAY, ST_SHIFT: begin
          if (bit_cnt_q != {CNT_W{1'b0}}) begin
            dacdat_d  = shift_q[DATA_W-1];
            shift_d   = {shift_q[DATA_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - CNT_W'(1);
            state_d   = ST_SHIFT;
          end else begin
            dacdat_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end
        ST_IDLE: begin
          dacdat_d = 1'b0;
          state_d  = ST_IDLE;
        end
        default: begin
          dacdat_d = 1'b0;
          state_d  = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Sample storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= sample_data;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sync_q    <= {SYNC_STAGES{1'b0}};
      lr_sync_q      <= {SYNC_STAGES{1'b0}};
      bclk_prev_q    <= 1'b0;
      lr_prev_q      <= 1'b0;
      wr_ptr_q       <= {PTR_W{1'b0}};
      rd_ptr_q       <= {PTR_W{1'b0}};
      level_q        <= {LVL_W{1'b0}};
      sample_ready_q <= 1'b0;
      hold_q         <= {DATA_W{1'b0}};
      underrun_q     <= 16'd0;
      state_q        <= ST_IDLE;
      shift_q        <= {DATA_W{1'b0}};
      bit_cnt_q      <= {CNT_W{1'b0}};
      dacdat_q       <= 1'b0;
    end else begin
      bclk_sync_q    <= bclk_sync_d;
      lr_sync_q      <= lr_sync_d;
      bclk_prev_q    <= bclk_prev_d;
      lr_prev_q      <= lr_prev_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      sample_ready_q <= sample_ready_d;
      hold_q         <= hold_d;
      underrun_q     <= underrun_d;
      state_q        <= state_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      dacdat_q       <= dacdat_d;
    end
  end

  assign sample_ready = sample_ready_q;
  assign dacdat_o     = dacdat_q;
  assign fifo_level   = level_q;
  assign underrun_cnt = underrun_q;

endmodule

// File: doc/audio_dac_serializer.md
# audio_dac_serializer

Serializes the theremin's mono 16-bit audio samples into I2S format for the WM8731 DAC input (dacdat), running with the codec as bit/frame-clock master (bclk, daclrck driven by the codec). It sits directly downstream of the synthesis/volume stage, which pushes samples over an Avalon-ST-style valid/ready sink, and upstream of the dacdat pad. A small FIFO absorbs producer jitter; each sample is sent identically on left and right channels.

## Interface
- DATA_W, 16: sample width in bits; also the number of bits shifted per channel slot.
- FIFO_DEPTH, 4: sample FIFO entries; power of two, ≥2.
- SYNC_STAGES, 2: flip-flop stages on bclk_i and daclrck_i.

- clk  in  1  system clock (50 MHz); one clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- sample_data  in  DATA_W  signed two's-complement sample.
- sample_valid  in  1  sample_data valid this cycle.
- sample_ready  out  1  FIFO can accept; transfer when valid && ready.
- mute  in  1  when 1, serialize zeros (FIFO still drained at frame rate).
- bclk_i  in  1  codec bit clock (asynchronous to clk).
- daclrck_i  in  1  codec frame clock; low = left, high = right.
- dacdat_o  out  1  serial data to codec.
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- underrun_cnt  out  16  count of frames started with empty FIFO, saturating at 0xFFFF.

## Operation
- Synchronize bclk_i, daclrck_i through SYNC_STAGES flops; bclk_fall = sync'd bclk was 1, now 0 (one-cycle pulse).
- On each bclk_fall: sample sync'd daclrck into lr_now; lr_prev holds value from previous bclk_fall.
- Serializer states: IDLE, DELAY, SHIFT.
  - Any state, bclk_fall with lr_now != lr_prev: frame/channel start -> load shift register, bit_cnt=DATA_W, drive dacdat_o=0, go DELAY (I2S one-bclk MSB delay). A channel start mid-SHIFT aborts the current word.
  - DELAY, next bclk_fall: dacdat_o=shift[MSB], shift<<=1, bit_cnt-=1, go SHIFT.
  - SHIFT, bclk_fall: while bit_cnt>0 output next bit as above; when bit_cnt reaches 0, drive 0 and go IDLE.
  - IDLE: dacdat_o=0 on all bclk_fall without channel start.
- Word source: left start (lr_now=0) pops FIFO into hold register; if FIFO empty, hold register keeps previous sample and underrun_cnt increments (saturating). Right start (lr_now=1) reuses hold register, no pop.
- Shift register loads mute ? 0 : hold value (post-pop value on left start).
- FIFO: push when sample_valid && sample_ready; sample_ready = (fifo_level < FIFO_DEPTH). Pop and push same cycle: pop evaluated on pre-push contents (empty FIFO + simultaneous push = underrun, pushed word stays). Full + pop: ready is already 0 that cycle, no push. Pointers wrap modulo FIFO_DEPTH; level updates +1/-1/0.

## Timing
- Reset (while reset=1, and first cycle after): dacdat_o=0, sample_ready=0 during reset then 1, fifo_level=0, underrun_cnt=0, hold=0, state IDLE, lr_prev=0, sync flops=0.
- Reset mid-word: word discarded; serializer restarts at next channel start.
- dacdat_o changes exactly SYNC_STAGES+1 clk cycles after the bclk_i pad falling edge; requires bclk high and low phases ≥ SYNC_STAGES+3 clk periods (met for bclk ≤ 3.072 MHz at 50 MHz clk).
- sample_ready reflects the registered level; a push is visible in fifo_level the cycle after handshake.
- Pop occurs in the same clk cycle as the left-start bclk_fall pulse.

## Test plan
- Reset then idle bclk: dacdat_o=0, fifo_level=0, sample_ready=1, underrun_cnt=0.
- Push 0xA5C3, run bclk=3.072 MHz, 32 bclk/channel: left slot emits 0 then 1010010111000011 MSB-first, rest 0; right slot identical; fifo_level 1->0.
- Push 5 samples with no bclk: first 4 accepted, sample_ready=0 on 5th, fifo_level=4; after one frame level 3, ready=1.
- Empty FIFO at two left starts after sample 0x7FFF: both frames repeat 0x7FFF, underrun_cnt=2.
- mute=1 with 0x8000 queued: dacdat_o stays 0 entire frame, fifo_level decrements by 1.
- Assert reset halfway through left word: dacdat_o=0 next cycle, FIFO empty; next left start emits hold=0, underrun_cnt=1.
